// File: rtl/me_wb_pipe_if.sv
// Data-memory bus between the ME stage (master) and data memory (slave).
interface me_wb_pipe_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/me_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with data-memory wait stall and a sticky watchdog.
// Optional: define ME_WB_VALID_QUALIFY_EN to AND the w_select outputs with their stage valid.
module me_wb_pipe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              flush_ex,
    input  logic [4:0]        ex_rd,
    input  logic [4:0]        ex_rs2,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic [1:0]        ex_w_select,
    input  logic              ex_rs2_r_select,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic              forward_data,
    me_wb_pipe_if.master      dmem_bus,
    output logic              me_valid,
    output logic [4:0]        me_rd,
    output logic [4:0]        me_rs2,
    output logic              me_mem_read,
    output logic              me_mem_write,
    output logic [1:0]        me_w_select,
    output logic              me_rs2_r_select,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [1:0]        wb_w_select,
    output logic [DATA_W-1:0] wb_data,
    output logic              pipe_stall,
    output logic              mem_timeout
);
    localparam logic [7:0] WAIT_MAX  = 8'(TIMEOUT);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic              me_valid_q, me_valid_d;
    logic [4:0]        me_rd_q, me_rd_d, me_rs2_q, me_rs2_d;
    logic              me_mem_read_q, me_mem_read_d, me_mem_write_q, me_mem_write_d;
    logic [1:0]        me_w_select_q, me_w_select_d;
    logic              me_rs2_r_select_q, me_rs2_r_select_d;
    logic [DATA_W-1:0] me_alu_result_q, me_alu_result_d, me_store_data_q, me_store_data_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [1:0]        wb_w_select_q, wb_w_select_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [7:0]        wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic              req, stall, ex_live;

    assign req     = me_valid_q & (me_mem_read_q | me_mem_write_q);
    assign stall   = req & ~dmem_bus.dmem_ready;
    assign ex_live = ex_valid & ~flush_ex;

    assign dmem_bus.dmem_req   = req;
    assign dmem_bus.dmem_we    = me_mem_write_q & me_valid_q;
    assign dmem_bus.dmem_addr  = me_alu_result_q;
    assign dmem_bus.dmem_wdata = forward_data ? wb_data_q : me_store_data_q;

    always_comb begin
        me_valid_d        = me_valid_q;
        me_rd_d           = me_rd_q;
        me_rs2_d          = me_rs2_q;
        me_mem_read_d     = me_mem_read_q;
        me_mem_write_d    = me_mem_write_q;
        me_w_select_d     = me_w_select_q;
        me_rs2_r_select_d = me_rs2_r_select_q;
        me_alu_result_d   = me_alu_result_q;
        me_store_data_d   = me_store_data_q;
        wb_valid_d        = 1'b0;
        wb_rd_d           = wb_rd_q;
        wb_w_select_d     = 2'b00;
        wb_data_d         = wb_data_q;
        if (!stall) begin
            // Flushed/invalid captures are turned into bubbles that cannot write or touch memory.
            me_valid_d        = ex_live;
            me_rd_d           = ex_rd;
            me_rs2_d          = ex_rs2;
            me_mem_read_d     = ex_mem_read & ex_live;
            me_mem_write_d    = ex_mem_write & ex_live;
            me_w_select_d     = ex_live ? ex_w_select : 2'b00;
            me_rs2_r_select_d = ex_rs2_r_select;
            me_alu_result_d   = ex_alu_result;
            me_store_data_d   = ex_store_data;
            wb_valid_d        = me_valid_q;
            wb_rd_d           = me_rd_q;
            wb_w_select_d     = me_w_select_q;
            wb_data_d         = me_mem_read_q ? dmem_bus.dmem_rdata : me_alu_result_q;
        end
        wait_d    = stall ? ((wait_q == WAIT_MAX) ? wait_q : wait_q + 8'd1) : '0;
        timeout_d = timeout_q | (stall & (wait_q == WAIT_LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            me_valid_q        <= 1'b0;
            me_rd_q           <= '0;
            me_rs2_q          <= '0;
            me_mem_read_q     <= 1'b0;
            me_mem_write_q    <= 1'b0;
            me_w_select_q     <= '0;
            me_rs2_r_select_q <= 1'b0;
            me_alu_result_q   <= '0;
            me_store_data_q   <= '0;
            wb_valid_q        <= 1'b0;
            wb_rd_q           <= '0;
            wb_w_select_q     <= '0;
            wb_data_q         <= '0;
            wait_q            <= '0;
            timeout_q         <= 1'b0;
        end else begin
            me_valid_q        <= me_valid_d;
            me_rd_q           <= me_rd_d;
            me_rs2_q          <= me_rs2_d;
            me_mem_read_q     <= me_mem_read_d;
            me_mem_write_q    <= me_mem_write_d;
            me_w_select_q     <= me_w_select_d;
            me_rs2_r_select_q <= me_rs2_r_select_d;
            me_alu_result_q   <= me_alu_result_d;
            me_store_data_q   <= me_store_data_d;
            wb_valid_q        <= wb_valid_d;
            wb_rd_q           <= wb_rd_d;
            wb_w_select_q     <= wb_w_select_d;
            wb_data_q         <= wb_data_d;
            wait_q            <= wait_d;
            timeout_q         <= timeout_d;
        end
    end

    assign me_valid        = me_valid_q;
    assign me_rd           = me_rd_q;
    assign me_rs2          = me_rs2_q;
    assign me_mem_read     = me_mem_read_q;
    assign me_mem_write    = me_mem_write_q;
    assign me_rs2_r_select = me_rs2_r_select_q;
    assign wb_valid        = wb_valid_q;
    assign wb_rd           = wb_rd_q;
    assign wb_data         = wb_data_q;
    assign pipe_stall      = stall;
    assign mem_timeout     = timeout_q;

`ifdef ME_WB_VALID_QUALIFY_EN
    assign me_w_select = me_w_select_q & {2{me_valid_q}};
    assign wb_w_select = wb_w_select_q & {2{wb_valid_q}};
`else
    assign me_w_select = me_w_select_q;
    assign wb_w_select = wb_w_select_q;
`endif
endmodule

// File: tb/tb_me_wb_pipe.sv
// Directed bench for me_wb_pipe: a vector table for single-cycle flows plus stall/flush/watchdog sequences.
module tb_me_wb_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, flush_ex, ex_mem_read, ex_mem_write, ex_rs2_r_select, forward_data;
    logic [4:0]  ex_rd, ex_rs2;
    logic [1:0]  ex_w_select;
    logic [31:0] ex_alu_result, ex_store_data;
    logic        me_valid, me_mem_read, me_mem_write, me_rs2_r_select;
    logic [4:0]  me_rd, me_rs2, wb_rd;
    logic [1:0]  me_w_select, wb_w_select;
    logic        wb_valid, pipe_stall, mem_timeout;
    logic [31:0] wb_data;
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    me_wb_pipe_if #(.DATA_W(32)) dmem_if ();

    me_wb_pipe #(.DATA_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .flush_ex(flush_ex),
        .ex_rd(ex_rd), .ex_rs2(ex_rs2), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_w_select(ex_w_select), .ex_rs2_r_select(ex_rs2_r_select),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .forward_data(forward_data), .dmem_bus(dmem_if),
        .me_valid(me_valid), .me_rd(me_rd), .me_rs2(me_rs2), .me_mem_read(me_mem_read),
        .me_mem_write(me_mem_write), .me_w_select(me_w_select), .me_rs2_r_select(me_rs2_r_select),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_w_select(wb_w_select), .wb_data(wb_data),
        .pipe_stall(pipe_stall), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ex_valid, flush;
        logic [4:0]  rd;
        logic        mr, mw;
        logic [1:0]  wsel;
        logic [31:0] alu;
        logic        ready;
        logic [31:0] rdata;
        logic        e_mev;
        logic [4:0]  e_merd;
        logic [1:0]  e_mews;
        logic        e_wbv;
        logic [4:0]  e_wbrd;
        logic [1:0]  e_wbws;
        logic [31:0] e_wbd;
        logic        e_req, e_stall;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic fl, input logic [4:0] rd, input logic mr,
                            input logic mw, input logic [1:0] ws, input logic [31:0] alu);
        ex_valid = v; flush_ex = fl; ex_rd = rd; ex_mem_read = mr; ex_mem_write = mw;
        ex_w_select = ws; ex_alu_result = alu;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 2'b01, 32'h1234, 1'b1, 32'h0,
                    1'b1, 5'd5, 2'b01, 1'b0, 5'd0, 2'b00, 32'h0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 2'b01, 32'h100, 1'b1, 32'h0,
                    1'b1, 5'd7, 2'b01, 1'b1, 5'd5, 2'b01, 32'h1234, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 2'b01, 32'h300, 1'b1, 32'h5555AAAA,
                    1'b0, 5'd9, 2'b00, 1'b1, 5'd7, 2'b01, 32'h5555AAAA, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b01, 32'h77, 1'b1, 32'h0,
                    1'b0, 5'd0, 2'b00, 1'b0, 5'd9, 2'b00, 32'h300, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 2'b10, 32'hFFFFFFFF, 1'b0, 32'h0,
                    1'b1, 5'd0, 2'b10, 1'b0, 5'd0, 2'b00, 32'h77, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 2'b11, 32'h10, 1'b0, 32'h0,
                    1'b1, 5'd3, 2'b11, 1'b1, 5'd0, 2'b10, 32'hFFFFFFFF, 1'b0, 1'b0};

        rst = 1'b1;
        drive_ex(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 32'h0);
        ex_rs2 = '0; ex_rs2_r_select = 1'b0; ex_store_data = '0; forward_data = 1'b0;
        dmem_if.dmem_ready = 1'b1; dmem_if.dmem_rdata = '0;
        tick(); tick();
        chk("rst_me_valid", 32'(me_valid), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_me_wsel", 32'(me_w_select), 32'd0);
        chk("rst_wb_wsel", 32'(wb_w_select), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_stall", 32'(pipe_stall), 32'd0);
        chk("rst_timeout", 32'(mem_timeout), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive_ex(vecs[i].ex_valid, vecs[i].flush, vecs[i].rd, vecs[i].mr, vecs[i].mw,
                     vecs[i].wsel, vecs[i].alu);
            dmem_if.dmem_ready = vecs[i].ready;
            dmem_if.dmem_rdata = vecs[i].rdata;
            tick();
            chk($sformatf("v%0d_me_valid", i), 32'(me_valid), 32'(vecs[i].e_mev));
            chk($sformatf("v%0d_me_rd", i), 32'(me_rd), 32'(vecs[i].e_merd));
            chk($sformatf("v%0d_me_wsel", i), 32'(me_w_select), 32'(vecs[i].e_mews));
            chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
            chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].e_wbrd));
            chk($sformatf("v%0d_wb_wsel", i), 32'(wb_w_select), 32'(vecs[i].e_wbws));
            chk($sformatf("v%0d_wb_data", i), wb_data, vecs[i].e_wbd);
            chk($sformatf("v%0d_req", i), 32'(dmem_if.dmem_req), 32'(vecs[i].e_req));
            chk($sformatf("v%0d_stall", i), 32'(pipe_stall), 32'(vecs[i].e_stall));
        end

        // Load held by three not-ready cycles.
        drive_ex(1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 2'b01, 32'h40);
        dmem_if.dmem_ready = 1'b0;
        tick();
        chk("ld_stall0", 32'(pipe_stall), 32'd1);
        chk("ld_addr", dmem_if.dmem_addr, 32'h40);
        chk("ld_we", 32'(dmem_if.dmem_we), 32'd0);
        drive_ex(1'b1, 1'b0, 5'd20, 1'b0, 1'b0, 2'b01, 32'h5);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ld_hold_me_rd%0d", i), 32'(me_rd), 32'd12);
            chk($sformatf("ld_bubble_v%0d", i), 32'(wb_valid), 32'd0);
            chk($sformatf("ld_bubble_ws%0d", i), 32'(wb_w_select), 32'd0);
            chk($sformatf("ld_bubble_rd%0d", i), 32'(wb_rd), 32'd3);
            chk($sformatf("ld_stall%0d", i + 1), 32'(pipe_stall), 32'd1);
        end
        dmem_if.dmem_ready = 1'b1;
        dmem_if.dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_stall_drop", 32'(pipe_stall), 32'd0);
        tick();
        chk("ld_wb_data", wb_data, 32'hDEADBEEF);
        chk("ld_wb_rd", 32'(wb_rd), 32'd12);
        chk("ld_wb_valid", 32'(wb_valid), 32'd1);
        chk("ld_me_next", 32'(me_rd), 32'd20);
        chk("ld_no_timeout", 32'(mem_timeout), 32'd0);

        // Store whose data is forwarded from WB.
        drive_ex(1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 2'b01, 32'hCAFE);
        tick();
        drive_ex(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 32'h80);
        ex_rs2 = 5'd1; ex_rs2_r_select = 1'b1; ex_store_data = 32'h1111;
        tick();
        chk("st_wb_data", wb_data, 32'hCAFE);
        chk("st_me_rs2", 32'(me_rs2), 32'd1);
        chk("st_rs2_sel", 32'(me_rs2_r_select), 32'd1);
        forward_data = 1'b1;
        #1;
        chk("st_fwd_wdata", dmem_if.dmem_wdata, 32'hCAFE);
        chk("st_we", 32'(dmem_if.dmem_we), 32'd1);
        chk("st_addr", dmem_if.dmem_addr, 32'h80);
        forward_data = 1'b0;
        #1;
        chk("st_raw_wdata", dmem_if.dmem_wdata, 32'h1111);

        // Flush ignored during a stall, honoured once memory is ready.
        dmem_if.dmem_ready = 1'b0;
        drive_ex(1'b1, 1'b1, 5'd30, 1'b0, 1'b0, 2'b01, 32'h9);
        #1;
        chk("fl_stall", 32'(pipe_stall), 32'd1);
        tick();
        chk("fl_hold_valid", 32'(me_valid), 32'd1);
        chk("fl_hold_mw", 32'(me_mem_write), 32'd1);
        chk("fl_hold_rd", 32'(me_rd), 32'd0);
        dmem_if.dmem_ready = 1'b1;
        tick();
        chk("fl_me_valid", 32'(me_valid), 32'd0);
        chk("fl_me_wsel", 32'(me_w_select), 32'd0);
        chk("fl_req", 32'(dmem_if.dmem_req), 32'd0);

        // Watchdog: TIMEOUT=4 stall cycles on a load.
        drive_ex(1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 2'b01, 32'h44);
        dmem_if.dmem_ready = 1'b0;
        tick();
        drive_ex(1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 2'b01, 32'h66);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("wd_timeout%0d", i + 1), 32'(mem_timeout), (i == 3) ? 32'd1 : 32'd0);
        end
        dmem_if.dmem_ready = 1'b1;
        tick();
        chk("wd_sticky1", 32'(mem_timeout), 32'd1);
        chk("wd_me_rd", 32'(me_rd), 32'd6);
        tick();
        chk("wd_sticky2", 32'(mem_timeout), 32'd1);

        // Reset in the middle of a stall.
        drive_ex(1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 2'b01, 32'h88);
        dmem_if.dmem_ready = 1'b0;
        tick();
        chk("rs_stall", 32'(pipe_stall), 32'd1);
        rst = 1'b1;
        tick();
        chk("rs_me_valid", 32'(me_valid), 32'd0);
        chk("rs_wb_valid", 32'(wb_valid), 32'd0);
        chk("rs_stall_drop", 32'(pipe_stall), 32'd0);
        chk("rs_timeout_clr", 32'(mem_timeout), 32'd0);
        chk("rs_me_wsel", 32'(me_w_select), 32'd0);
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/me_wb_pipe.md
# me_wb_pipe

EX/MEM and MEM/WB pipeline registers for the matrix-extended core, with data-memory wait handling. Captures the EX-stage result, then produces every ME/WB-side field that the forwarding unit consumes (`me_rd`, `me_rs2`, `me_mem_write`, `me_w_select`, `me_rs2_r_select`, `wb_rd`, `wb_w_select`). Stalls upstream while data memory is not ready and flags a stuck memory with a watchdog.

## Interface
- `DATA_W`, 32: result/data width.
- `TIMEOUT`, 64: consecutive not-ready cycles before `mem_timeout` sets; range 1..255.

Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.

- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `ex_valid` in 1: EX holds a real instruction.
- `flush_ex` in 1: drop the EX instruction (branch/jump redirect).
- `ex_rd`, `ex_rs2` in 5 each: destination and store-source register indices.
- `ex_mem_read`, `ex_mem_write` in 1 each: load / store.
- `ex_w_select` in 2: 00 none, 01 scalar RF, 10 matrix element, 11 matrix whole.
- `ex_rs2_r_select` in 1: 1 = rs2 is scalar, 0 = matrix.
- `ex_alu_result`, `ex_store_data` in DATA_W each.
- `dmem_ready` in 1: data memory accepts/returns this cycle.
- `dmem_rdata` in DATA_W: load data, valid when `dmem_ready`.
- `forward_data` in 1: from forwarding; select `wb_data` as store data.
- `dmem_req` out 1: `me_valid & (me_mem_read | me_mem_write)`.
- `dmem_we` out 1, `dmem_addr` out DATA_W, `dmem_wdata` out DATA_W.
- `me_valid`, `me_rd`, `me_rs2`, `me_mem_read`, `me_mem_write`, `me_w_select`, `me_rs2_r_select`: EX/MEM register outputs.
- `wb_valid`, `wb_rd`, `wb_w_select`, `wb_data` (DATA_W): MEM/WB register outputs.
- `pipe_stall` out 1: hold PC/IF/ID/EX this cycle.
- `mem_timeout` out 1: sticky watchdog error.

## Operation
- `dmem_addr = me_alu_result`; `dmem_we = me_mem_write & me_valid`.
- `dmem_wdata = forward_data ? wb_data : me_store_data`.
- `pipe_stall = dmem_req & ~dmem_ready`. This output is combinational.
- EX/MEM register:
  - When `pipe_stall` is 0, it captures all EX fields. `me_valid <= ex_valid & ~flush_ex`.
  - A flushed or invalid capture forces `me_w_select <= 00`, `me_mem_read <= 0` and `me_mem_write <= 0`.
  - When `pipe_stall` is 1, it holds. `flush_ex` is ignored that cycle; upstream re-asserts it after the stall.
- MEM/WB register:
  - When `pipe_stall` is 0, it captures `me_valid`, `me_rd` and `me_w_select`. `wb_data <= me_mem_read ? dmem_rdata : me_alu_result`.
  - When `pipe_stall` is 1, it loads a bubble: `wb_valid <= 0`, `wb_w_select <= 00`, and `wb_rd`/`wb_data` are held.
- Watchdog `wait_cnt` (8 bits):
  - Increments while `pipe_stall` is 1 and clears otherwise. It saturates at TIMEOUT.
  - `mem_timeout` sets when `wait_cnt == TIMEOUT-1` and the stall is still active. It clears only on `rst`.
- State per stage: EMPTY (valid=0) / FULL (valid=1). Stage-level WAIT is FULL with `pipe_stall`=1.

## Timing
- Reset: all valid bits 0, all `w_select` 00, rd/rs2/data/result 0, flags 0, `wait_cnt` 0, `mem_timeout` 0.
- Latency: EX→ME 1 cycle, ME→WB 1 cycle when `dmem_ready`; each wait cycle adds 1.
- Non-memory ME instruction never stalls, whatever `dmem_ready` is.
- A single-cycle memory (ready same cycle as req) gives zero stall.
- `flush_ex` together with `ex_valid` in a non-stall cycle produces a bubble in ME the next cycle.
- `rst` during a stall empties both stages next cycle and drops `pipe_stall`; the watchdog clears.
- `rd = 0` is passed through unmodified. Filtering x0 is the forwarding unit's job.

## Configuration
- `ME_WB_VALID_QUALIFY_EN` defined:
  - `me_w_select` and `wb_w_select` outputs are ANDed with their valid bit. A bubble can never drive a forwarding hazard, even if a held `w_select` is stale.
- Undefined:
  - The raw registered `w_select` is output, relying on the bubble-forcing above.
  - Identical behaviour for all legal flows; it differs only if a register is corrupted or forced.

## Test plan
- Reset: assert `rst` 2 cycles -> all valids 0, `me_w_select`=`wb_w_select`=00, `pipe_stall`=0, `mem_timeout`=0.
- ALU op: rd=5, w_select=01, result 0x1234 in EX -> `me_rd`=5 at cycle+1, `wb_rd`=5 and `wb_data`=0x1234 at cycle+2.
- Load with 3-cycle wait: `dmem_ready` low 3 cycles, then high with rdata 0xDEADBEEF:
  - `pipe_stall`=1 for 3 cycles and ME holds.
  - WB gets 3 bubbles with `wb_w_select`=00.
  - Next cycle `wb_data`=0xDEADBEEF.
- Store forwarding: `wb_data`=0xCAFE, store in ME with `forward_data`=1 -> `dmem_wdata`=0xCAFE and `dmem_we`=1.
- Flush: `ex_valid`=1, `flush_ex`=1 with no stall -> `me_valid`=0, `me_w_select`=00, `dmem_req`=0. With a stall active, ME is unchanged.
- Watchdog with TIMEOUT=4: hold `dmem_ready` low on a load -> `mem_timeout` rises after 4 stall cycles. It stays 1 after ready returns and clears only on `rst`.
